// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - SD controller register map, field sizes and command sequencer states
package sd_pkg;

    localparam int CMD_REG_SIZE = 14;
    localparam int INT_CMD_SIZE = 5;

    localparam logic [6:0] ADDR_ARGUMENT = 7'h00;
    localparam logic [6:0] ADDR_COMMAND  = 7'h04;
    localparam logic [6:0] ADDR_RESP0    = 7'h08;
    localparam logic [6:0] ADDR_CMD_ISR  = 7'h34;

    localparam int ISR_CC_BIT = 0;
    localparam int ISR_EI_BIT = 1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        POLL,
        RD,
        CLR,
        CLR_WAIT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - issues one SD command over the byte register bus and returns its result
module sd_cmd_sequencer
    import sd_pkg::*;
#(
    parameter int POLL_LIMIT = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CMD_REG_SIZE-1:0] req_cmd,
    input  logic [31:0]             req_arg,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [INT_CMD_SIZE-1:0] rsp_status,
    output logic [31:0]             rsp_resp,
    output logic                    rsp_timeout,
    output logic                    bus_we,
    output logic [6:0]              bus_addr,
    output logic [7:0]              bus_wdata,
    input  logic [7:0]              bus_rdata
);

    localparam int              CNT_W    = $clog2(POLL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_LIMIT - 1);

    seq_state_t              state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [CMD_REG_SIZE-1:0] cmd_q, cmd_d;
    logic [31:0]             arg_q, arg_d;
    logic [INT_CMD_SIZE-1:0] status_q, status_d;
    logic [31:0]             resp_q, resp_d;
    logic                    timeout_q, timeout_d;
    logic [15:0]             cmd_ext;

    assign cmd_ext     = 16'(cmd_q);
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign rsp_status  = status_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = timeout_q;

    // Bus and handshake outputs depend only on registered state, never on bus_rdata
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == DONE);
        bus_we    = 1'b0;
        bus_addr  = 7'h00;
        bus_wdata = 8'h00;
        case (state_q)
            WR: begin
                bus_we = 1'b1;
                case (idx_q)
                    3'd0:    begin bus_addr = ADDR_COMMAND;          bus_wdata = cmd_ext[7:0];  end
                    3'd1:    begin bus_addr = ADDR_COMMAND + 7'd1;   bus_wdata = cmd_ext[15:8]; end
                    3'd2:    begin bus_addr = ADDR_ARGUMENT + 7'd3;  bus_wdata = arg_q[31:24];  end
                    3'd3:    begin bus_addr = ADDR_ARGUMENT + 7'd2;  bus_wdata = arg_q[23:16];  end
                    3'd4:    begin bus_addr = ADDR_ARGUMENT + 7'd1;  bus_wdata = arg_q[15:8];   end
                    default: begin bus_addr = ADDR_ARGUMENT;         bus_wdata = arg_q[7:0];    end
                endcase
            end
            POLL, CLR_WAIT: bus_addr = ADDR_CMD_ISR;
            RD:             bus_addr = ADDR_RESP0 + {5'd0, idx_q[1:0]};
            CLR: begin
                bus_we   = 1'b1;
                bus_addr = ADDR_CMD_ISR;
            end
            default: ;
        endcase
    end

    // Next-state: argument byte0 goes last because writing it launches the command
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        status_d  = status_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cmd_d     = req_cmd;
                    arg_d     = req_arg;
                    status_d  = '0;
                    resp_d    = '0;
                    timeout_d = 1'b0;
                    idx_d     = 3'd0;
                    state_d   = WR;
                end
            end
            WR: begin
                if (idx_q == 3'd5) begin
                    cnt_d   = '0;
                    state_d = POLL;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            POLL: begin
                if (bus_rdata[ISR_CC_BIT] || bus_rdata[ISR_EI_BIT]) begin
                    status_d = bus_rdata[INT_CMD_SIZE-1:0];
                    if (bus_rdata[ISR_EI_BIT]) begin
                        resp_d  = '0;
                        state_d = CLR;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = RD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    status_d  = bus_rdata[INT_CMD_SIZE-1:0];
                    resp_d    = '0;
                    state_d   = CLR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RD: begin
                resp_d[{idx_q[1:0], 3'b000} +: 8] = bus_rdata;
                if (idx_q[1:0] == 2'd3) begin
                    state_d = CLR;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = CLR_WAIT;
            end
            CLR_WAIT: begin
                // The clear lands on the slower sd_clk, so wait for the register to read back empty
                if (bus_rdata == 8'h00) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any command in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            cnt_q     <= '0;
            cmd_q     <= '0;
            arg_q     <= '0;
            status_q  <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            status_q  <= status_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
